// File: rtl/calc_sequencer.sv
// calc_sequencer: byte-stream front end and result stage for the
// combinational 8-bit calculator. Collects opcode/A/B, holds the calculator
// inputs for a settle window, captures the result and hands it out with an
// error flag. Divide-by-zero is replaced by 16'hFFFF with out_err set.
module calc_sequencer #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic [7:0]       calc_first_num,
    output logic [7:0]       calc_second_num,
    output logic [1:0]       calc_operation,
    input  logic [15:0]      calc_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic             out_err,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [2:0] {
        S_GET_OP = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_EXEC   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // Counter is loaded with EXEC_CYCLES-1 so the capture edge lands exactly
    // EXEC_CYCLES edges after the operand-B handshake.
    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [7:0]       first_q, first_d;
    logic [7:0]       second_q, second_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_result_q, out_result_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] ops_q, ops_d;
    logic             in_hs_s;
    logic             unused_in_bits_s;

    // Division with a zero divisor is the only case the sequencer overrides.
    function automatic logic is_div_zero(input logic [1:0] op, input logic [7:0] divisor);
        return (op == 2'b11) && (divisor == 8'd0);
    endfunction

    assign in_hs_s          = in_valid && in_ready_q;
    assign unused_in_bits_s = ^in_data[7:2];

    // Next-state and next-output computation for the command sequencer.
    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        first_d      = first_q;
        second_d     = second_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;
        ops_d        = ops_q;
        case (state_q)
            S_GET_OP: begin
                in_ready_d = 1'b1;
                if (in_hs_s) begin
                    op_d    = in_data[1:0];
                    state_d = S_GET_A;
                end else begin
                    state_d = S_GET_OP;
                end
            end
            S_GET_A: begin
                in_ready_d = 1'b1;
                if (in_hs_s) begin
                    first_d = in_data;
                    state_d = S_GET_B;
                end else begin
                    state_d = S_GET_A;
                end
            end
            S_GET_B: begin
                if (in_hs_s) begin
                    second_d   = in_data;
                    cnt_d      = EXEC_LOAD;
                    in_ready_d = 1'b0;
                    state_d    = S_EXEC;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = S_GET_B;
                end
            end
            S_EXEC: begin
                in_ready_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    out_valid_d = 1'b1;
                    state_d     = S_RESP;
                    if (is_div_zero(op_q, second_q)) begin
                        out_result_d = 16'hFFFF;
                        out_err_d    = 1'b1;
                    end else begin
                        out_result_d = calc_result;
                        out_err_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ops_d       = ops_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    in_ready_d  = 1'b1;
                    state_d     = S_GET_OP;
                end else begin
                    in_ready_d = 1'b0;
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                state_d     = S_GET_OP;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_GET_OP;
            in_ready_q   <= 1'b0;
            first_q      <= 8'd0;
            second_q     <= 8'd0;
            op_q         <= 2'd0;
            cnt_q        <= 4'd0;
            out_valid_q  <= 1'b0;
            out_result_q <= 16'd0;
            out_err_q    <= 1'b0;
            ops_q        <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            first_q      <= first_d;
            second_q     <= second_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
            ops_q        <= ops_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign calc_first_num  = first_q;
    assign calc_second_num = second_q;
    assign calc_operation  = op_q;
    assign out_valid       = out_valid_q;
    assign out_result      = out_result_q;
    assign out_err         = out_err_q;
    assign ops_done        = ops_q;

endmodule
